// File: rtl/pixel_serializer.sv
// Two-slot group buffer that serialises NUM_ENGINES-pixel groups onto an AXI4-Stream video master.
// Build macro PIXEL_SERIALIZER_TEST_PATTERN_EN adds a test_mode port that replaces tdata with an x/y pattern.
module pixel_serializer #(
    parameter int NUM_ENGINES = 3,
    parameter int RGB_SIZE    = 24,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [RGB_SIZE-1:0]    in_rgb [NUM_ENGINES-1:0],
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [TDATA_WIDTH-1:0] out_tdata,
    output logic                   out_tvalid,
    input  logic                   out_tready,
`ifdef PIXEL_SERIALIZER_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    output logic                   out_tuser,
    output logic                   out_tlast
);
    localparam int LW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(NUM_ENGINES - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(Y_SIZE - 1);

    logic [RGB_SIZE-1:0] slot [2][NUM_ENGINES];
    logic                wp;
    logic                rp;
    logic [1:0]          occ;
    logic [LW-1:0]       lane;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;

    logic                   accept;
    logic                   fire;
    logic                   frame_end;
    logic                   release_slot;
    logic [RGB_SIZE-1:0]    cur_rgb;
    logic [TDATA_WIDTH-1:0] pixel_data;

    // Both ports are valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; valid and payload stay stable until then, and ready here depends on registers only.
    always_comb begin
        in_ready     = (occ != 2'd2);
        out_tvalid   = (occ != 2'd0);
        accept       = in_valid & in_ready;
        fire         = out_tvalid & out_tready;
        frame_end    = (x == X_LAST) && (y == Y_LAST);
        release_slot = fire & ((lane == LANE_LAST) | frame_end);
    end

    always_comb begin
        cur_rgb    = slot[rp][lane];
        pixel_data = TDATA_WIDTH'(cur_rgb);
`ifdef PIXEL_SERIALIZER_TEST_PATTERN_EN
        if (test_mode) begin
            pixel_data = TDATA_WIDTH'({8'(x), 8'(y), 8'hFF});
        end
`endif
        // Sideband and data read as zero while idle so reset and empty look identical.
        out_tdata = out_tvalid ? pixel_data : '0;
        out_tuser = out_tvalid & (x == '0) & (y == '0);
        out_tlast = out_tvalid & (x == X_LAST);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            occ  <= 2'd0;
            lane <= '0;
            x    <= '0;
            y    <= '0;
        end else begin
            if (accept) begin
                wp <= ~wp;
            end
            if (release_slot) begin
                rp <= ~rp;
            end
            case ({accept, release_slot})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (fire) begin
                // A frame ending mid-group drops the leftover lanes so the next group opens a frame.
                lane <= release_slot ? '0 : lane + LW'(1);
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Payload needs no reset: it is only observable once occupancy marks the slot as filled.
    always_ff @(posedge aclk) begin
        if (accept) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot[wp][i] <= in_rgb[i];
            end
        end
    end

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer on a 4x2 frame with three lanes: vector table plus
// hand-written back-to-back, backpressure, mid-frame reset and (optional) test-pattern runs.
module tb_pixel_serializer;
    localparam int NE = 3;
    localparam int RW = 24;
    localparam int XS = 4;
    localparam int YS = 2;
    localparam int TW = 32;
    localparam int GW = NE * RW;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [RW-1:0] in_rgb [NE-1:0];
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic          out_tuser;
    logic          out_tlast;
    logic          test_mode = 1'b0;

    int tests = 0;
    int fails = 0;

    // scoreboard: queue of buffered groups plus the reference lane/x/y position
    logic [GW-1:0] exp_q[$];
    int m_lane, m_x, m_y;

    pixel_serializer #(
        .NUM_ENGINES(NE), .RGB_SIZE(RW), .X_SIZE(XS), .Y_SIZE(YS), .TDATA_WIDTH(TW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .in_rgb(in_rgb),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_tdata(out_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
`ifdef PIXEL_SERIALIZER_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .out_tuser(out_tuser),
        .out_tlast(out_tlast)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [RW-1:0] pix(input int k);
        pix = 24'(k) * 24'h010101;
    endfunction

    function automatic logic [GW-1:0] grp(input int k);
        grp = {pix(k + 2), pix(k + 1), pix(k)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_group(input logic [GW-1:0] g);
        for (int i = 0; i < NE; i++) in_rgb[i] = g[i*RW +: RW];
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        in_valid = 1'b0;
        out_tready = 1'b0;
        exp_q.delete();
        m_lane = 0;
        m_x = 0;
        m_y = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // One clock of scoreboard-checked traffic; acc reports whether the group was taken.
    task automatic step(input logic v, input logic [GW-1:0] g, input logic rdy, output logic acc);
        logic [TW-1:0] exp_data;
        logic          fire;
        @(negedge aclk);
        in_valid = v;
        drive_group(g);
        out_tready = rdy;
        #1;
        check("sb_tvalid", out_tvalid, exp_q.size() != 0);
        check("sb_in_ready", in_ready, exp_q.size() < 2);
        if (out_tvalid && exp_q.size() != 0) begin
            exp_data = TW'(exp_q[0][m_lane*RW +: RW]);
            if (test_mode) exp_data = TW'({8'(m_x), 8'(m_y), 8'hFF});
            check("sb_tdata", out_tdata, exp_data);
            check("sb_tuser", out_tuser, (m_x == 0) && (m_y == 0));
            check("sb_tlast", out_tlast, m_x == XS - 1);
            if (test_mode && m_x == 3 && m_y == 1) check("tp_pixel_3_1", out_tdata, 32'h000301FF);
        end
        fire = rdy && (exp_q.size() != 0);
        acc = v && (exp_q.size() < 2);
        if (fire) begin
            if (m_lane == NE - 1 || (m_x == XS - 1 && m_y == YS - 1)) begin
                void'(exp_q.pop_front());
                m_lane = 0;
            end else begin
                m_lane++;
            end
            if (m_x == XS - 1) begin
                m_x = 0;
                m_y = (m_y == YS - 1) ? 0 : m_y + 1;
            end else begin
                m_x++;
            end
        end
        if (acc) exp_q.push_back(g);
    endtask

    typedef struct {
        logic          vin;
        logic [GW-1:0] grp;
        logic          rdy;
        logic          e_valid;
        logic [RW-1:0] e_data;
        logic          e_user;
        logic          e_last;
        logic          e_ready;
    } vec_t;

    function automatic vec_t mkv(input logic vin, input logic [GW-1:0] g, input logic rdy,
                                 input logic ev, input logic [RW-1:0] ed, input logic eu,
                                 input logic el, input logic er);
        vec_t r;
        r.vin = vin; r.grp = g; r.rdy = rdy;
        r.e_valid = ev; r.e_data = ed; r.e_user = eu; r.e_last = el; r.e_ready = er;
        return r;
    endfunction

    vec_t vecs [13];

    initial begin
        logic acc;
        int   k;
        int   reached;

        // small frame: A..L = pix(1..12); I (pix 9) is dropped at frame end
        vecs[0]  = mkv(1, grp(1),  1, 0, 0,       0, 0, 1);
        vecs[1]  = mkv(1, grp(4),  1, 1, pix(1),  1, 0, 1);
        vecs[2]  = mkv(1, grp(7),  1, 1, pix(2),  0, 0, 0);
        vecs[3]  = mkv(1, grp(7),  1, 1, pix(3),  0, 0, 0);
        vecs[4]  = mkv(1, grp(7),  1, 1, pix(4),  0, 1, 1);
        vecs[5]  = mkv(0, '0,      1, 1, pix(5),  0, 0, 0);
        vecs[6]  = mkv(0, '0,      1, 1, pix(6),  0, 0, 0);
        vecs[7]  = mkv(1, grp(10), 1, 1, pix(7),  0, 0, 1);
        vecs[8]  = mkv(0, '0,      1, 1, pix(8),  0, 1, 0);
        vecs[9]  = mkv(0, '0,      1, 1, pix(10), 1, 0, 1);
        vecs[10] = mkv(0, '0,      1, 1, pix(11), 0, 0, 1);
        vecs[11] = mkv(0, '0,      1, 1, pix(12), 0, 0, 1);
        vecs[12] = mkv(0, '0,      1, 0, 0,       0, 0, 1);

        // reset held with a valid group offered
        drive_group(grp(1));
        in_valid = 1'b1;
        out_tready = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            #1;
            check("rst_tvalid", out_tvalid, 1'b0);
            check("rst_tdata", out_tdata, 32'h0);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_tuser", out_tuser, 1'b0);
            check("rst_tlast", out_tlast, 1'b0);
        end
        @(negedge aclk);
        in_valid = 1'b0;
        aresetn = 1'b1;
        repeat (2) begin
            @(negedge aclk);
            #1;
            check("rst_no_accept", out_tvalid, 1'b0);
        end

        // table-driven small frame
        for (int i = 0; i < 13; i++) begin
            @(negedge aclk);
            in_valid = vecs[i].vin;
            drive_group(vecs[i].grp);
            out_tready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_tvalid", i), out_tvalid, vecs[i].e_valid);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ready);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_tdata", i), out_tdata, TW'(vecs[i].e_data));
                check($sformatf("vec%0d_tuser", i), out_tuser, vecs[i].e_user);
                check($sformatf("vec%0d_tlast", i), out_tlast, vecs[i].e_last);
            end
        end

        // back-to-back: in_valid always high, sink always ready
        do_reset();
        k = 1;
        for (int c = 0; c < 60; c++) begin
            step(1'b1, grp(k), 1'b1, acc);
            if (acc) k += 3;
        end
        repeat (8) step(1'b0, '0, 1'b1, acc);

        // backpressure: stall 5 cycles while B (pix 2) is presented
        do_reset();
        step(1'b1, grp(1), 1'b1, acc);
        step(1'b1, grp(4), 1'b1, acc);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, grp(7), 1'b0, acc);
            check("bp_hold_tdata", out_tdata, TW'(pix(2)));
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        k = 7;
        for (int c = 0; c < 6; c++) begin
            step(k <= 7, grp(k), 1'b1, acc);
            if (acc) k += 3;
        end
        repeat (8) step(1'b0, '0, 1'b1, acc);

        // reset mid-frame once the DUT sits at x=2, y=1
        do_reset();
        k = 100;
        reached = 0;
        for (int c = 0; c < 40 && reached == 0; c++) begin
            step(1'b1, grp(k), 1'b1, acc);
            if (acc) k += 3;
            if (m_x == 2 && m_y == 1 && exp_q.size() != 0) reached = 1;
        end
        tests++;
        if (reached == 0) begin
            fails++;
            $display("FAIL midrst_reach: got x=%0d y=%0d expected x=2 y=1", m_x, m_y);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_tvalid", out_tvalid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        m_lane = 0;
        m_x = 0;
        m_y = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        step(1'b1, grp(200), 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        check("midrst_first_tdata", out_tdata, TW'(pix(200)));
        check("midrst_first_tuser", out_tuser, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1, acc);

`ifdef PIXEL_SERIALIZER_TEST_PATTERN_EN
        // test pattern over a full frame; pixel (3,1) checked against 32'h000301FF
        do_reset();
        test_mode = 1'b1;
        k = 50;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, grp(k), 1'b1, acc);
            if (acc) k += 3;
        end
        repeat (8) step(1'b0, '0, 1'b1, acc);
        test_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_serializer.md
Name: pixel_serializer

Overview:
- Downstream neighbour of the iteration-to-colour LUT stage.
- Accepts one group of NUM_ENGINES RGB pixels per handshake. The group holds consecutive raster pixels, lane 0 first.
- Buffers up to two groups and emits one pixel per clock on an AXI4-Stream video master.
- Tags start-of-frame (tuser) and end-of-line (tlast) from internal x/y counters.

Parameters:
- NUM_ENGINES, 3, pixels per input group (lanes).
- RGB_SIZE, 24, bits per input pixel.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- TDATA_WIDTH, 32, output data width; must be >= RGB_SIZE.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- in_rgb  in  [NUM_ENGINES-1:0] x RGB_SIZE (unpacked array)  lane colours
- in_valid  in  1  group valid
- in_ready  out  1  group can be accepted
- out_tdata  out  TDATA_WIDTH  {zero pad, rgb}
- out_tvalid  out  1  stream valid
- out_tready  in  1  stream ready
- out_tuser  out  1  first pixel of frame (x=0, y=0)
- out_tlast  out  1  last pixel of line (x=X_SIZE-1)

Behaviour:
- Reset values (async, aresetn=0):
  - out_tvalid=0, out_tdata=0, out_tuser=0, out_tlast=0, in_ready=1.
  - Both slots empty; read lane=0; x=0, y=0.
- Storage:
  - 2-slot group buffer with write pointer, read pointer and occupancy (0..2).
  - Input handshake = in_valid & in_ready. It writes in_rgb to the write slot, then wp flips and occupancy increments.
  - in_ready = (occupancy < 2). It is a function of registered state only, with no combinational path from out_tready.
  - A full buffer stalls input even if a slot frees in the same cycle.
- Output path:
  - out_tvalid = (occupancy > 0).
  - out_tdata = slot[rp][lane], zero-extended to TDATA_WIDTH.
  - out_tuser = (x==0 && y==0).
  - out_tlast = (x==X_SIZE-1).
  - Outputs are held stable while out_tvalid & !out_tready.
- Latency:
  - A group accepted at edge N makes out_tvalid high after edge N (cycle N+1) when the buffer was empty.
  - No bubbles between groups while the second slot is filled.
- On output handshake:
  - Pixel advance: x increments; at X_SIZE-1, x wraps to 0 and y increments. At (X_SIZE-1, Y_SIZE-1), both wrap to 0.
  - Lane advance: lane increments. At lane NUM_ENGINES-1 the slot is released: lane goes to 0, rp flips and occupancy decrements.
  - Frame end: if the pixel sent was (X_SIZE-1, Y_SIZE-1) and lane < NUM_ENGINES-1, the remaining lanes of that group are dropped. The slot is released immediately and lane goes to 0, so the next group starts a new frame.
- Simultaneous accept and release in one cycle: occupancy is unchanged, both pointers flip, and no data is lost.
- Lines may span group boundaries, because X_SIZE need not be a multiple of NUM_ENGINES.
- Sustained throughput is 1 pixel/clk. in_valid is accepted at most once per NUM_ENGINES cycles in steady state.
- Mid-operation reset: all state is cleared immediately and buffered pixels are discarded. The first pixel after reset carries tuser=1.

Optional Feature:
- Macro: PIXEL_SERIALIZER_TEST_PATTERN_EN.
- Defined:
  - Extra input port test_mode (1 bit).
  - When test_mode=1, out_tdata = {pad, x[7:0], y[7:0], 8'hFF}.
  - Input groups are still consumed and sequenced identically; only tdata content changes.
  - test_mode is sampled per pixel; the bench changes it only while out_tvalid=0 or on handshake boundaries.
- Undefined: no test_mode port; tdata is always the buffered RGB.

Test Plan:
- Reset: hold aresetn=0 with in_valid=1 -> out_tvalid=0, out_tdata=0, in_ready=1. No group accepted until release.
- Small frame (X_SIZE=4, Y_SIZE=2, NUM_ENGINES=3, out_tready=1), groups {A,B,C}, {D,E,F}, {G,H,I} -> tdata A..H on consecutive cycles; tuser only on A; tlast on D and H; I dropped. Next group {J,K,L} emits J with tuser=1.
- Back-to-back (default params, in_valid=1 always, out_tready=1) -> out_tvalid continuously 1 after the first group; in_ready shows a handshake every 3 cycles; tlast every 640 pixels; tuser every 307200 pixels.
- Backpressure: out_tready=0 for 5 cycles while pixel B is presented -> tdata/tuser/tlast held at B. in_ready drops after two groups are buffered. After release, pixel order is unchanged with no loss or duplication.
- Reset mid-frame at x=2, y=1 -> out_tvalid=0 immediately. After release the first group's lane 0 is emitted with tuser=1, x restarts at 0.
- PIXEL_SERIALIZER_TEST_PATTERN_EN with test_mode=1 at pixel (x=3, y=1) -> out_tdata=32'h000301FF, and tlast matches the RGB-mode run.
